// File: rtl/instruction_decode_stage_if.sv
// rtl/instruction_decode_stage_if.sv - instruction input and decoded record output bundle
interface instruction_decode_stage_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instruction;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [2:0]      out_type;
    logic [3:0]      out_alu_op;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [31:0]     out_imm;
    logic            out_illegal;

    // master: fetch side producer plus execute side consumer
    modport master (
        output in_valid, in_instruction, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_type, out_alu_op,
               out_rd, out_rs1, out_rs2, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, in_instruction, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_type, out_alu_op,
               out_rd, out_rs1, out_rs2, out_imm, out_illegal
    );
endinterface

// File: rtl/instruction_decode_stage.sv
// rtl/instruction_decode_stage.sv - RV32I decode stage with output record FIFO and debug counters
module instruction_decode_stage #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    instruction_decode_stage_if.slave dif,
    output logic [CNT_W-1:0]          decoded_count,
    output logic [CNT_W-1:0]          illegal_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [3:0] {
        ALU_ADD     = 4'd0,
        ALU_SUB     = 4'd1,
        ALU_SLL     = 4'd2,
        ALU_SLT     = 4'd3,
        ALU_SLTU    = 4'd4,
        ALU_XOR     = 4'd5,
        ALU_SRL     = 4'd6,
        ALU_SRA     = 4'd7,
        ALU_OR      = 4'd8,
        ALU_AND     = 4'd9,
        ALU_INVALID = 4'd15
    } alu_control_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [2:0]      itype;
        logic [3:0]      alu;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic            illegal;
    } rec_t;

    logic [31:0]  inst;
    logic [6:0]   opcode;
    logic [2:0]   f3;
    logic [6:0]   f7;
    logic [2:0]   itype;
    alu_control_t alu;
    logic [31:0]  imm;
    rec_t         dec_rec;

    always_comb begin
        inst   = dif.in_instruction;
        opcode = inst[6:0];
        f3     = inst[14:12];
        f7     = inst[31:25];
        itype  = 3'b111;
        alu    = ALU_INVALID;
        imm    = '0;
        case (opcode)
            7'd51: begin
                itype = 3'd0;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: alu = ALU_ADD;
                        3'd1: alu = ALU_SLL;
                        3'd2: alu = ALU_SLT;
                        3'd3: alu = ALU_SLTU;
                        3'd4: alu = ALU_XOR;
                        3'd5: alu = ALU_SRL;
                        3'd6: alu = ALU_OR;
                        3'd7: alu = ALU_AND;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    alu = ALU_SUB;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    alu = ALU_SRA;
                end
            end
            7'd19: begin
                itype = 3'd1;
                imm   = {{20{inst[31]}}, inst[31:20]};
                // funct7 only qualifies the shift encodings
                case (f3)
                    3'd0: alu = ALU_ADD;
                    3'd1: if (f7 == 7'h00) alu = ALU_SLL;
                    3'd2: alu = ALU_SLT;
                    3'd3: alu = ALU_SLTU;
                    3'd4: alu = ALU_XOR;
                    3'd5: begin
                        if (f7 == 7'h00)      alu = ALU_SRL;
                        else if (f7 == 7'h20) alu = ALU_SRA;
                    end
                    3'd6: alu = ALU_OR;
                    3'd7: alu = ALU_AND;
                endcase
            end
            7'd3: begin
                itype = 3'd2;
                alu   = ALU_ADD;
                imm   = {{20{inst[31]}}, inst[31:20]};
            end
            7'd35: begin
                itype = 3'd3;
                alu   = ALU_ADD;
                imm   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'd99: begin
                itype = 3'd4;
                imm   = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                case (f3)
                    3'd0, 3'd1: alu = ALU_SUB;
                    3'd4, 3'd5: alu = ALU_SLT;
                    3'd6, 3'd7: alu = ALU_SLTU;
                    default:    alu = ALU_INVALID;
                endcase
            end
            7'd55: begin
                itype = 3'd5;
                alu   = ALU_ADD;
                imm   = {inst[31:12], 12'b0};
            end
            7'd111: begin
                itype = 3'd6;
                alu   = ALU_ADD;
                imm   = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
                itype = 3'b111;
                alu   = ALU_INVALID;
                imm   = '0;
            end
        endcase
        dec_rec.pc      = dif.in_pc;
        dec_rec.itype   = itype;
        dec_rec.alu     = alu;
        dec_rec.rd      = inst[11:7];
        dec_rec.rs1     = inst[19:15];
        dec_rec.rs2     = inst[24:20];
        dec_rec.imm     = imm;
        dec_rec.illegal = (itype == 3'b111) || (alu == ALU_INVALID);
    end

    rec_t             mem_q [DEPTH];
    rec_t             mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic             push, pop, in_ready, out_valid;
    rec_t             head, out_rec;

    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign push      = dif.in_valid & in_ready;
    assign pop       = out_valid & dif.out_ready;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dec_cnt_d = dec_cnt_q;
        ill_cnt_d = ill_cnt_q;
        // a pop coinciding with a flush still reaches the consumer, so it is counted
        if (pop && dec_cnt_q != '1) dec_cnt_d = dec_cnt_q + 1'b1;
        if (pop && head.illegal && ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + 1'b1;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec_rec;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dec_cnt_q <= '0;
            ill_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dec_cnt_q <= dec_cnt_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign out_rec         = out_valid ? head : '0;
    assign dif.in_ready    = in_ready;
    assign dif.out_valid   = out_valid;
    assign dif.out_pc      = out_rec.pc;
    assign dif.out_type    = out_rec.itype;
    assign dif.out_alu_op  = out_rec.alu;
    assign dif.out_rd      = out_rec.rd;
    assign dif.out_rs1     = out_rec.rs1;
    assign dif.out_rs2     = out_rec.rs2;
    assign dif.out_imm     = out_rec.imm;
    assign dif.out_illegal = out_rec.illegal;
    assign decoded_count   = dec_cnt_q;
    assign illegal_count   = ill_cnt_q;
endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb/tb_instruction_decode_stage.sv - table-driven scoreboard bench for instruction_decode_stage
module tb_instruction_decode_stage;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLT = 4'd3, A_XOR = 4'd5;
    localparam logic [3:0] A_SRA = 4'd7, A_INV = 4'd15;
    localparam int NV = 15;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  typ;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
        logic        chk_alu;
        logic        chk_imm;
    } vec_t;

    logic clk = 1'b0;
    logic rst, flush, rst2, flush2;
    logic [15:0] dc, ic;
    logic [1:0]  dc2, ic2;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0;
    logic [15:0] m_dec = '0;
    logic [15:0] m_ill = '0;
    logic [15:0] save_dc, save_ic;
    vec_t exp_q[$];
    vec_t tbl[NV];
    vec_t e_mon;

    instruction_decode_stage_if #(.PC_W(32)) dif ();
    instruction_decode_stage_if #(.PC_W(32)) dif2 ();

    instruction_decode_stage #(.DEPTH(2), .PC_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .dif(dif.slave),
        .decoded_count(dc), .illegal_count(ic)
    );

    instruction_decode_stage #(.DEPTH(2), .PC_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst2), .flush(flush2), .dif(dif2.slave),
        .decoded_count(dc2), .illegal_count(ic2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc, input logic [2:0] typ,
                                input logic [3:0] alu, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm, input logic ill,
                                input logic chk_alu, input logic chk_imm);
        vec_t v;
        v.instr = instr; v.pc = pc; v.typ = typ; v.alu = alu; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.ill = ill; v.chk_alu = chk_alu; v.chk_imm = chk_imm;
        return v;
    endfunction

    // offers one instruction until accepted; the expectation is queued on acceptance
    task automatic drive(input vec_t v);
        dif.in_valid       = 1'b1;
        dif.in_instruction = v.instr;
        dif.in_pc          = v.pc;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (dif.in_ready) begin
                exp_q.push_back(v);
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL drive_timeout: pc 0x%08h never accepted, expected acceptance", v.pc);
    endtask

    task automatic idle();
        dif.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_dec = '0;
            m_ill = '0;
        end else begin
            if (dif.out_valid && dif.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_record: got pc 0x%08h expected no record", dif.out_pc);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("out_pc", dif.out_pc, e_mon.pc);
                    check("out_type", 32'(dif.out_type), 32'(e_mon.typ));
                    if (e_mon.chk_alu) check("out_alu_op", 32'(dif.out_alu_op), 32'(e_mon.alu));
                    check("out_rd", 32'(dif.out_rd), 32'(e_mon.rd));
                    check("out_rs1", 32'(dif.out_rs1), 32'(e_mon.rs1));
                    check("out_rs2", 32'(dif.out_rs2), 32'(e_mon.rs2));
                    if (e_mon.chk_imm) check("out_imm", dif.out_imm, e_mon.imm);
                    check("out_illegal", 32'(dif.out_illegal), 32'(e_mon.ill));
                    if (m_dec != 16'hFFFF) m_dec = m_dec + 1'b1;
                    if (e_mon.ill && m_ill != 16'hFFFF) m_ill = m_ill + 1'b1;
                end
            end
            if (flush) exp_q.delete();
        end
    end

    initial begin
        rst = 1'b0; flush = 1'b0; rst2 = 1'b0; flush2 = 1'b0;
        dif.in_valid = 1'b0; dif.in_instruction = '0; dif.in_pc = '0; dif.out_ready = 1'b0;
        dif2.in_valid = 1'b0; dif2.in_instruction = '0; dif2.in_pc = '0; dif2.out_ready = 1'b0;

        tbl[0]  = mk(32'h40208133, 32'h100, 3'd0, A_SUB, 2,  1, 2,  32'h0,        0, 1, 1);
        tbl[1]  = mk(32'hFFF00093, 32'h104, 3'd1, A_ADD, 1,  0, 31, 32'hFFFFFFFF, 0, 1, 1);
        tbl[2]  = mk(32'hFE000EE3, 32'h108, 3'd4, A_SUB, 29, 0, 0,  32'hFFFFFFFC, 0, 1, 1);
        tbl[3]  = mk(32'h40101093, 32'h10C, 3'd1, A_INV, 1,  0, 1,  32'h0,        1, 1, 0);
        tbl[4]  = mk(32'h0000007F, 32'h110, 3'd7, A_INV, 0,  0, 0,  32'h0,        1, 0, 1);
        tbl[5]  = mk(32'h00412083, 32'h114, 3'd2, A_ADD, 1,  2, 4,  32'h4,        0, 1, 1);
        tbl[6]  = mk(32'hFE112E23, 32'h118, 3'd3, A_ADD, 28, 2, 1,  32'hFFFFFFFC, 0, 1, 1);
        tbl[7]  = mk(32'h123452B7, 32'h11C, 3'd5, A_ADD, 5,  8, 3,  32'h12345000, 0, 1, 1);
        tbl[8]  = mk(32'h0080006F, 32'h120, 3'd6, A_ADD, 0,  0, 8,  32'h8,        0, 1, 1);
        tbl[9]  = mk(32'h4030D093, 32'h124, 3'd1, A_SRA, 1,  1, 3,  32'h403,      0, 1, 1);
        tbl[10] = mk(32'h02208133, 32'h128, 3'd0, A_INV, 2,  1, 2,  32'h0,        1, 1, 1);
        tbl[11] = mk(32'h0020D463, 32'h12C, 3'd4, A_SLT, 8,  1, 2,  32'h8,        0, 1, 1);
        tbl[12] = mk(32'h00002063, 32'h130, 3'd4, A_INV, 0,  0, 0,  32'h0,        1, 1, 1);
        tbl[13] = mk(32'h0020C1B3, 32'h134, 3'd0, A_XOR, 3,  1, 2,  32'h0,        0, 1, 1);
        tbl[14] = mk(32'h00000013, 32'h138, 3'd1, A_ADD, 0,  0, 0,  32'h0,        0, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rst2 = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 32'(dif.out_valid), 32'd0);
        check("reset_in_ready", 32'(dif.in_ready), 32'd1);
        check("reset_decoded_count", 32'(dc), 32'd0);
        check("reset_illegal_count", 32'(ic), 32'd0);
        check("reset_out_imm", dif.out_imm, 32'd0);

        // single add, popped the cycle after it is pushed
        @(posedge clk);
        #1;
        dif.out_ready = 1'b1;
        drive(mk(32'h002081B3, 32'h0, 3'd0, A_ADD, 3, 1, 2, 32'h0, 0, 1, 1));
        idle();
        check("first_out_valid", 32'(dif.out_valid), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("first_decoded_count", 32'(dc), 32'd1);

        // full decode table back to back, one accept per cycle
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int i = 0; i < NV; i++) drive(tbl[i]);
        idle();
        check("table_throughput_cycles", 32'(cyc - c0), 32'(NV));
        repeat (4) @(negedge clk);
        check("table_queue_drained", 32'(exp_q.size()), 32'd0);
        check("table_decoded_count", 32'(dc), 32'(m_dec));
        check("table_decoded_abs", 32'(dc), 32'd16);
        check("table_illegal_count", 32'(ic), 32'(m_ill));
        check("table_illegal_abs", 32'(ic), 32'd4);

        // backpressure: two accepts fill the buffer, third waits for a pop
        dif.out_ready = 1'b0;
        @(posedge clk);
        #1;
        drive(mk(32'h002081B3, 32'h0, 3'd0, A_ADD, 3, 1, 2, 32'h0, 0, 1, 1));
        drive(mk(32'h002081B3, 32'h4, 3'd0, A_ADD, 3, 1, 2, 32'h0, 0, 1, 1));
        idle();
        @(negedge clk);
        check("bp_full_in_ready", 32'(dif.in_ready), 32'd0);
        check("bp_full_out_valid", 32'(dif.out_valid), 32'd1);
        dif.out_ready = 1'b1;
        drive(mk(32'h002081B3, 32'h8, 3'd0, A_ADD, 3, 1, 2, 32'h0, 0, 1, 1));
        idle();
        repeat (4) @(negedge clk);
        check("bp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("bp_decoded_count", 32'(dc), 32'(m_dec));

        // flush with a full buffer and a concurrent offer
        dif.out_ready = 1'b0;
        @(posedge clk);
        #1;
        drive(mk(32'h0000007F, 32'h200, 3'd7, A_INV, 0, 0, 0, 32'h0, 1, 0, 1));
        drive(mk(32'h0000007F, 32'h204, 3'd7, A_INV, 0, 0, 0, 32'h0, 1, 0, 1));
        save_dc = dc;
        save_ic = ic;
        dif.in_valid = 1'b1;
        dif.in_instruction = 32'h002081B3;
        dif.in_pc = 32'h208;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle();
        @(negedge clk);
        check("flush_out_valid", 32'(dif.out_valid), 32'd0);
        check("flush_out_pc", dif.out_pc, 32'd0);
        check("flush_decoded_count", 32'(dc), 32'(save_dc));
        check("flush_illegal_count", 32'(ic), 32'(save_ic));

        // flush with one entry: the concurrent push would be accepted but must be dropped
        @(posedge clk);
        #1;
        drive(mk(32'h00000013, 32'h300, 3'd1, A_ADD, 0, 0, 0, 32'h0, 0, 1, 1));
        dif.in_valid = 1'b1;
        dif.in_instruction = 32'h00000013;
        dif.in_pc = 32'h304;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle();
        @(negedge clk);
        check("flush1_out_valid", 32'(dif.out_valid), 32'd0);
        dif.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("flush_decoded_after", 32'(dc), 32'(save_dc));

        // reset while full
        dif.out_ready = 1'b0;
        @(posedge clk);
        #1;
        drive(mk(32'h002081B3, 32'h400, 3'd0, A_ADD, 3, 1, 2, 32'h0, 0, 1, 1));
        drive(mk(32'h002081B3, 32'h404, 3'd0, A_ADD, 3, 1, 2, 32'h0, 0, 1, 1));
        idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_full_out_valid", 32'(dif.out_valid), 32'd0);
        check("rst_full_in_ready", 32'(dif.in_ready), 32'd1);
        check("rst_full_decoded_count", 32'(dc), 32'd0);
        check("rst_full_illegal_count", 32'(ic), 32'd0);

        // 2-bit counters saturate at 3 after five illegal pops
        dif2.out_ready = 1'b1;
        dif2.in_valid = 1'b1;
        dif2.in_instruction = 32'h0000007F;
        repeat (5) @(posedge clk);
        #1;
        dif2.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("sat_decoded_count", 32'(dc2), 32'd3);
        check("sat_illegal_count", 32'(ic2), 32'd3);
        check("sat_out_valid", 32'(dif2.out_valid), 32'd0);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
